// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types for the MEM-stage data memory responder
// Purpose: state encoding and word-size constants used by dmem_responder.
// Ports: none (package).
package mips_pkg;

  typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_DONE} mem_state_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port word RAM, clocked write, combinational read
// Purpose: backing storage for dmem_responder; contents are never cleared.
// Ports:
//   clk   - clock, write on rising edge
//   we    - write enable
//   addr  - word index
//   wdata - write data
//   rdata - read data for addr (same cycle)
module dmem_ram #(
  parameter int  DEPTH_WORDS = 64,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency load/store responder for the MEM stage
// Purpose: accepts one request, stalls the pipeline for LATENCY cycles, then
//   pulses resp_valid; stores commit on the response cycle.
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   req_valid/we/addr/wdata - request from the MEM stage (byte address)
//   stall                  - hold IF..MEM this cycle
//   resp_valid             - one-cycle completion pulse
//   resp_rdata             - load data, held until the next response
//   resp_err               - misaligned access flag, only with resp_valid
module dmem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  mem_state_t      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [AW-1:0]   ram_addr;
  logic            ram_we;
  logic [31:0]     ram_rdata;
  logic            misaligned_q;
  logic            live_misaligned;
  logic            unused_addr_hi;

  // Address bits above the RAM index are deliberately dropped (address wrap).
  assign unused_addr_hi  = ^req_addr[31:AW+2];

  assign misaligned_q    = (addr_q[1:0] != 2'b00);
  assign live_misaligned = (req_addr[1:0] != 2'b00);

  // In IDLE the RAM looks at the live request so LATENCY=1 can read on the
  // acceptance edge; afterwards only the latched address is used.
  assign ram_addr = (state_q == MEM_IDLE) ? req_addr[2 +: AW] : addr_q[2 +: AW];
  assign ram_we   = (state_q == MEM_DONE) && we_q && !misaligned_q;

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MEM_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      MEM_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr[AW+1:0];
          wdata_d = req_wdata;
          if (LATENCY == 1) begin
            state_d = MEM_DONE;
            rdata_d = live_misaligned ? 32'd0 : ram_rdata;
          end else begin
            state_d = MEM_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      MEM_WAIT: begin
        // A dropped request is a pipeline flush: abandon without responding.
        if (!req_valid) begin
          state_d = MEM_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = MEM_DONE;
          rdata_d = misaligned_q ? 32'd0 : ram_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      MEM_DONE: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  assign stall      = ((state_q == MEM_IDLE) && req_valid) || (state_q == MEM_WAIT);
  assign resp_valid = (state_q == MEM_DONE);
  assign resp_err   = (state_q == MEM_DONE) && misaligned_q;
  assign resp_rdata = rdata_q;

endmodule
